// File: rtl/alu_pkg.sv
// Shared opcode, state and operand-descriptor definitions for the sequential Hack ALU.
// Comp codes are the six Hack control bits zx,nx,zy,ny,f,no; y carries A or M.
package alu_pkg;

  localparam int EXT_BIT = 6;

  localparam logic [5:0] C_ZERO = 6'b101010;
  localparam logic [5:0] C_ONE  = 6'b111111;
  localparam logic [5:0] C_NEG1 = 6'b111010;
  localparam logic [5:0] C_D    = 6'b001100;
  localparam logic [5:0] C_A    = 6'b110000;
  localparam logic [5:0] C_NOTD = 6'b001101;
  localparam logic [5:0] C_NOTA = 6'b110001;
  localparam logic [5:0] C_NEGD = 6'b001111;
  localparam logic [5:0] C_NEGA = 6'b110011;
  localparam logic [5:0] C_DP1  = 6'b011111;
  localparam logic [5:0] C_AP1  = 6'b110111;
  localparam logic [5:0] C_DM1  = 6'b001110;
  localparam logic [5:0] C_AM1  = 6'b110010;
  localparam logic [5:0] C_DPA  = 6'b000010;
  localparam logic [5:0] C_DMA  = 6'b010011;
  localparam logic [5:0] C_AMD  = 6'b000111;
  localparam logic [5:0] C_DANDA = 6'b000000;
  localparam logic [5:0] C_DORA  = 6'b010101;

  localparam logic [5:0] OP_MUL = 6'b000000;
  localparam logic [5:0] OP_SHL = 6'b000001;
  localparam logic [5:0] OP_SHR = 6'b000010;
  localparam logic [5:0] OP_SRA = 6'b000011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic       ext;
    logic [5:0] code;
  } op_t;

endpackage

// File: rtl/alu_hack_comb.sv
// Combinational decoder for the 18 Hack comp functions, zero-latency, no flow control.
// Codes outside the Hack set yield 0.
module alu_hack_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [5:0]       i_code,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic [WIDTH-1:0] o_res
);

  always_comb begin
    o_res = '0;
    case (i_code)
      C_ZERO:  o_res = '0;
      C_ONE:   o_res = WIDTH'(1);
      C_NEG1:  o_res = '1;
      C_D:     o_res = i_x;
      C_A:     o_res = i_y;
      C_NOTD:  o_res = ~i_x;
      C_NOTA:  o_res = ~i_y;
      C_NEGD:  o_res = -i_x;
      C_NEGA:  o_res = -i_y;
      C_DP1:   o_res = i_x + WIDTH'(1);
      C_AP1:   o_res = i_y + WIDTH'(1);
      C_DM1:   o_res = i_x - WIDTH'(1);
      C_AM1:   o_res = i_y - WIDTH'(1);
      C_DPA:   o_res = i_x + i_y;
      C_DMA:   o_res = i_x - i_y;
      C_AMD:   o_res = i_y - i_x;
      C_DANDA: o_res = i_x & i_y;
      C_DORA:  o_res = i_x | i_y;
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked Hack ALU with iterative MUL/shift ops; result valid k cycles after accept.
// Result and flags hold while out_valid && !out_ready; in_ready is low for all of BUSY.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zr,
  output logic             ng
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  state_t           r_state;
  state_t           w_state_nxt;
  op_t              r_op;
  op_t              w_op_in;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_res;
  logic             r_zr;
  logic             r_ng;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_k;
  logic             w_take;
  logic             w_last;
  logic             w_shamt_nz;
  logic [WIDTH-1:0] w_hack;
  logic [WIDTH-1:0] w_sh_nxt;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_fin;

  assign w_op_in    = op_t'(opcode);
  assign w_take     = in_valid && in_ready;
  assign w_last     = (r_state == BUSY) && (r_cnt == CW'(1));
  assign w_shamt_nz = |r_y[SHW-1:0];

  alu_hack_comb #(.WIDTH(WIDTH)) u_hack (
    .i_code (r_op.code),
    .i_x    (r_x),
    .i_y    (r_y),
    .o_res  (w_hack)
  );

  // Iteration count chosen from the live inputs so it can be loaded on the accept edge.
  always_comb begin
    w_k = CW'(1);
    if (opcode[EXT_BIT]) begin
      case (w_op_in.code)
        OP_MUL:                 w_k = CW'(WIDTH);
        OP_SHL, OP_SHR, OP_SRA: if (|y[SHW-1:0]) w_k = {1'b0, y[SHW-1:0]};
        default:                w_k = CW'(1);
      endcase
    end
  end

  always_comb begin
    w_sh_nxt = r_x;
    if (w_shamt_nz) begin
      case (r_op.code)
        OP_SHL:  w_sh_nxt = r_x << 1;
        OP_SHR:  w_sh_nxt = r_x >> 1;
        OP_SRA:  w_sh_nxt = {r_x[WIDTH-1], r_x[WIDTH-1:1]};
        default: w_sh_nxt = r_x;
      endcase
    end
  end

  assign w_acc_nxt = r_acc + (r_y[0] ? r_x : '0);

  always_comb begin
    w_fin = '0;
    if (!r_op.ext) begin
      w_fin = w_hack;
    end else begin
      case (r_op.code)
        OP_MUL:                 w_fin = w_acc_nxt;
        OP_SHL, OP_SHR, OP_SRA: w_fin = w_sh_nxt;
        default:                w_fin = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_take) w_state_nxt = BUSY;
      BUSY:    if (r_cnt == CW'(1)) w_state_nxt = DONE;
      DONE: begin
        if (w_take)         w_state_nxt = BUSY;
        else if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    out_valid = (r_state == DONE);
  end

  // Multiplier: r_x is the shifting multiplicand, r_y the shifting multiplier.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op  <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_res <= '0;
      r_zr  <= 1'b1;
      r_ng  <= 1'b0;
    end else if (w_take) begin
      r_op  <= w_op_in;
      r_x   <= x;
      r_y   <= y;
      r_acc <= '0;
      r_cnt <= w_k;
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_op.ext) begin
        case (r_op.code)
          OP_MUL: begin
            r_acc <= w_acc_nxt;
            r_x   <= r_x << 1;
            r_y   <= r_y >> 1;
          end
          OP_SHL, OP_SHR, OP_SRA: r_x <= w_sh_nxt;
          default: ;
        endcase
      end
      if (w_last) begin
        r_res <= w_fin;
        r_zr  <= (w_fin == '0);
        r_ng  <= w_fin[WIDTH-1];
      end
    end
  end

  assign result = r_res;
  assign zr     = r_zr;
  assign ng     = r_ng;

endmodule

// File: tb/tb_alu_seq.sv
// Directed vector table plus hand sequences for backpressure and mid-operation reset.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [15:0] x;
  logic [15:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        zr;
  logic        ng;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zr        (zr),
    .ng        (ng)
  );

  typedef struct {
    logic [6:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [6:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] res, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Offer one op, then measure edges until out_valid and check the result and flags.
  task automatic run_op(input string name, input logic [6:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] res, input int lat);
    int   waitc;
    int   got;
    logic rdy_seen;
    waitc = 0;
    out_ready = 1'b1;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    opcode = op; x = a; y = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; opcode = 7'h7F; x = 16'hDEAD; y = 16'hBEEF;
    got = 0;
    rdy_seen = 1'b0;
    while (!out_valid && got < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      got++;
    end
    check({name, " latency"}, 32'(got), 32'(lat));
    check({name, " busy in_ready"}, 32'(rdy_seen), 32'd0);
    check({name, " result"}, 32'(result), 32'(res));
    check({name, " zr"}, 32'(zr), 32'(res == 16'h0000));
    check({name, " ng"}, 32'(ng), 32'(res[15]));
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within cycle budget");
    $fatal(1);
  end

  initial begin
    int   cyc;
    logic seen;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; x = '0; y = '0;
    repeat (3) @(negedge clk);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset in_ready",  32'(in_ready),  32'd1);
    check("reset result",    32'(result),    32'd0);
    check("reset zr",        32'(zr),        32'd1);
    check("reset ng",        32'(ng),        32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    add_vec(7'b0_000010, 16'd3,     16'd5,     16'h0008, 1);
    add_vec(7'b0_010011, 16'd2,     16'd5,     16'hFFFD, 1);
    add_vec(7'b0_101010, 16'h1234,  16'h5678,  16'h0000, 1);
    add_vec(7'b0_111111, 16'h1234,  16'h5678,  16'h0001, 1);
    add_vec(7'b0_111010, 16'h1234,  16'h5678,  16'hFFFF, 1);
    add_vec(7'b0_001100, 16'h1234,  16'h5678,  16'h1234, 1);
    add_vec(7'b0_110000, 16'h1234,  16'hABCD,  16'hABCD, 1);
    add_vec(7'b0_001101, 16'h00FF,  16'h5678,  16'hFF00, 1);
    add_vec(7'b0_110001, 16'h1234,  16'h0F0F,  16'hF0F0, 1);
    add_vec(7'b0_001111, 16'h0001,  16'h5678,  16'hFFFF, 1);
    add_vec(7'b0_110011, 16'h1234,  16'h0002,  16'hFFFE, 1);
    add_vec(7'b0_011111, 16'hFFFF,  16'h5678,  16'h0000, 1);
    add_vec(7'b0_110111, 16'h1234,  16'h0007,  16'h0008, 1);
    add_vec(7'b0_001110, 16'h0000,  16'h5678,  16'hFFFF, 1);
    add_vec(7'b0_110010, 16'h1234,  16'h0000,  16'hFFFF, 1);
    add_vec(7'b0_000111, 16'd2,     16'd5,     16'h0003, 1);
    add_vec(7'b0_000000, 16'hC3C3,  16'h0FF0,  16'h03C0, 1);
    add_vec(7'b0_010101, 16'hC3C3,  16'h0FF0,  16'hCFF3, 1);
    add_vec(7'b0_000001, 16'h0005,  16'h0005,  16'h0000, 1);
    add_vec(7'b1_000000, 16'd300,   16'd300,   16'h5F90, 16);
    add_vec(7'b1_000000, 16'hFFFF,  16'hFFFF,  16'h0001, 16);
    add_vec(7'b1_000000, 16'h1234,  16'h0003,  16'h369C, 16);
    add_vec(7'b1_000000, 16'h0007,  16'h0000,  16'h0000, 16);
    add_vec(7'b1_000011, 16'h8000,  16'h0003,  16'hF000, 3);
    add_vec(7'b1_000011, 16'h4000,  16'h0002,  16'h1000, 2);
    add_vec(7'b1_000001, 16'h0001,  16'h0010,  16'h0001, 1);
    add_vec(7'b1_000001, 16'h0003,  16'h0004,  16'h0030, 4);
    add_vec(7'b1_000010, 16'h8000,  16'h000F,  16'h0001, 15);
    add_vec(7'b1_000111, 16'h0005,  16'h0005,  16'h0000, 1);

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
    end

    // Backpressure: result must hold and nothing is accepted until out_ready rises.
    @(negedge clk);
    out_ready = 1'b0;
    opcode = 7'b0_000010; x = 16'd3; y = 16'd5; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("bp first result", 32'(result), 32'h0008);
    opcode = 7'b0_110000; x = 16'h0000; y = 16'h0777; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp hold out_valid", 32'(out_valid), 32'd1);
      check("bp hold in_ready",  32'(in_ready),  32'd0);
      check("bp hold result",    32'(result),    32'h0008);
    end
    out_ready = 1'b1;
    #1;
    check("bp in_ready follows out_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp accepted busy", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("bp second valid",  32'(out_valid), 32'd1);
    check("bp second result", 32'(result),    32'h0777);

    // Reset five edges into a multiply must abort it cleanly.
    run_op("pre-reset add", 7'b0_000010, 16'd3, 16'd5, 16'h0008, 1);
    opcode = 7'b1_000000; x = 16'd300; y = 16'd300; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mul busy before reset", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst result",    32'(result),    32'd0);
    check("rst zr",        32'(zr),        32'd1);
    check("rst ng",        32'(ng),        32'd0);
    check("rst in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no stale result", 32'(seen), 32'd0);
    run_op("post-reset sra", 7'b1_000011, 16'h8000, 16'h0003, 16'hF000, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
